// File: rtl/control_seq.sv
// Multi-cycle instruction control sequencer: accepts one decoded instruction,
// runs an optional memory phase with ack/timeout, then a single writeback cycle.

`ifndef CONTROL_SEQ_DEFS
`define CONTROL_SEQ_DEFS
`define OP_SPEC   4'd0
`define OP_MOV    4'd1
`define OP_ADD    4'd2
`define OP_SUB    4'd3
`define OP_ASR    4'd4
`define OP_ASL    4'd5
`define OP_OR     4'd6
`define OP_AND    4'd7
`define OP_XOR    4'd8
`define OP_LSL    4'd9
`define OP_LSR    4'd10
`define OP_CND    4'd11
`define OP_LD     4'd12
`define OP_LDA    4'd13
`define OP_ST     4'd14
`define OP_CBR    4'd15
`define ALU_NOP   4'd0
`define ALU_MOV   4'd1
`define ALU_ADD   4'd2
`define ALU_SUB   4'd3
`define ALU_ASR   4'd4
`define ALU_ASL   4'd5
`define ALU_OR    4'd6
`define ALU_AND   4'd7
`define ALU_XOR   4'd8
`define ALU_LSL   4'd9
`define ALU_LSR   4'd10
`define ALU_CND   4'd11
`define RAM_NONE  2'd0
`define RAM_READ  2'd1
`define RAM_WRITE 2'd2
`define WB_NONE   2'd0
`define WB_RAM    2'd1
`define WB_PC     2'd2
`define WB_ALU    2'd3
`endif

module control_seq #(
  parameter int DW      = 32,
  parameter int RW      = 5,
  parameter int IW      = 16,
  parameter int TIMEOUT = 255,
  parameter int CW      = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_run,
  input  logic          i_inst_valid,
  output logic          o_inst_ready,
  input  logic [3:0]    i_inst,
  input  logic [IW-1:0] i_ir,
  input  logic [RW-1:0] i_reg0,
  input  logic [RW-1:0] i_reg1,
  input  logic [DW-1:0] i_val_reg0,
  input  logic [DW-1:0] i_val_reg1,
  input  logic [DW-1:0] i_pc_inc,
  input  logic          i_ram_ack,
  output logic [1:0]    o_ram_action,
  output logic [DW-1:0] o_ram_addr,
  output logic [3:0]    o_alu_action,
  output logic [RW-1:0] o_wb_reg,
  output logic [1:0]    o_wb_type,
  output logic          o_wb_en,
  output logic          o_do_jump,
  output logic [DW-1:0] o_pc_jump,
  output logic          o_retire,
  output logic [CW-1:0] o_retired,
  output logic          o_run,
  output logic          o_halt,
  output logic          o_fault,
  output logic [1:0]    o_state
);

  localparam int WCW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MEM = 2'd1, S_WB = 2'd2, S_HALT = 2'd3} state_t;

  state_t          state_q, state_d;
  logic [3:0]      op_q;
  logic [RW-1:0]   reg0_q, reg1_q;
  logic [DW-1:0]   val0_q, val1_q, pc_q;
  logic [WCW-1:0]  wait_q;
  logic [CW-1:0]   retired_q;
  logic            fault_q;
  logic            accept, is_mem_op, timeout_hit;
  logic [3:0]      alu_code;
  logic [1:0]      wb_type_c;
  logic            jump_c;
  logic [DW-1:0]   pc_jump_c;

  // Handshake: an instruction transfers on any rising edge where i_inst_valid
  // and o_inst_ready are both high; ready is only offered in IDLE while i_run.
  assign accept      = (state_q == S_IDLE) && i_run && i_inst_valid;
  assign is_mem_op   = (i_inst == `OP_LD) || (i_inst == `OP_LDA) || (i_inst == `OP_ST);
  assign timeout_hit = (TIMEOUT != 0) && (wait_q == WCW'(TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (i_ir == '0)     state_d = S_HALT;
          else if (is_mem_op) state_d = S_MEM;
          else                state_d = S_WB;
        end
      end
      // Ack takes priority over a timeout landing in the same cycle.
      S_MEM: begin
        if (i_ram_ack)        state_d = S_WB;
        else if (timeout_hit) state_d = S_HALT;
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      op_q      <= `OP_SPEC;
      reg0_q    <= '0;
      reg1_q    <= '0;
      val0_q    <= '0;
      val1_q    <= '0;
      pc_q      <= '0;
      wait_q    <= '0;
      retired_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      if (accept) begin
        op_q   <= i_inst;
        reg0_q <= i_reg0;
        reg1_q <= i_reg1;
        val0_q <= i_val_reg0;
        val1_q <= i_val_reg1;
        pc_q   <= i_pc_inc;
        wait_q <= '0;
      end
      if (state_q == S_MEM && !i_ram_ack) begin
        wait_q <= wait_q + 1'b1;
        if (timeout_hit) fault_q <= 1'b1;
      end
      // Count on entry so the WB cycle already shows the new total.
      if (state_d == S_WB && state_q != S_WB) retired_q <= retired_q + 1'b1;
    end
  end

  always_comb begin
    alu_code = `ALU_NOP;
    case (op_q)
      `OP_MOV: alu_code = `ALU_MOV;
      `OP_ADD: alu_code = `ALU_ADD;
      `OP_SUB: alu_code = `ALU_SUB;
      `OP_ASR: alu_code = `ALU_ASR;
      `OP_ASL: alu_code = `ALU_ASL;
      `OP_OR:  alu_code = `ALU_OR;
      `OP_AND: alu_code = `ALU_AND;
      `OP_XOR: alu_code = `ALU_XOR;
      `OP_LSL: alu_code = `ALU_LSL;
      `OP_LSR: alu_code = `ALU_LSR;
      `OP_CND: alu_code = `ALU_CND;
      default: alu_code = `ALU_NOP;
    endcase
  end

  always_comb begin
    wb_type_c = `WB_NONE;
    jump_c    = 1'b0;
    pc_jump_c = val1_q;
    if (op_q == `OP_LD || op_q == `OP_LDA) wb_type_c = `WB_RAM;
    else if (op_q == `OP_CBR)              wb_type_c = `WB_PC;
    else if (alu_code != `ALU_NOP)         wb_type_c = `WB_ALU;
    if (op_q == `OP_CBR) jump_c = (val0_q != '0);
    if (op_q == `OP_LDA) begin
      jump_c    = 1'b1;
      pc_jump_c = pc_q + DW'(DW / 8);
    end
  end

  always_comb begin
    o_inst_ready = 1'b0;
    o_ram_action = `RAM_NONE;
    o_ram_addr   = '0;
    o_wb_en      = 1'b0;
    o_do_jump    = 1'b0;
    o_retire     = 1'b0;
    o_halt       = 1'b0;
    case (state_q)
      S_IDLE: o_inst_ready = i_run;
      S_MEM: begin
        o_ram_action = (op_q == `OP_ST) ? `RAM_WRITE : `RAM_READ;
        if (op_q == `OP_LD)       o_ram_addr = val0_q;
        else if (op_q == `OP_LDA) o_ram_addr = pc_q;
        else                      o_ram_addr = val1_q;
      end
      S_WB: begin
        o_retire  = 1'b1;
        o_wb_en   = (wb_type_c != `WB_NONE);
        o_do_jump = jump_c;
      end
      default: o_halt = 1'b1;
    endcase
  end

  assign o_alu_action = alu_code;
  assign o_wb_type    = wb_type_c;
  assign o_wb_reg     = (op_q == `OP_CBR) ? reg0_q : reg1_q;
  assign o_pc_jump    = pc_jump_c;
  assign o_retired    = retired_q;
  assign o_fault      = fault_q;
  assign o_run        = i_run && (state_q != S_HALT);
  assign o_state      = state_q;

endmodule

// File: tb/tb_control_seq.sv
// Directed bench for control_seq: scoreboard of expected writeback records,
// plus direct checks on memory phase, timeout, halt and reset behaviour.

`ifndef CONTROL_SEQ_DEFS
`define CONTROL_SEQ_DEFS
`define OP_SPEC   4'd0
`define OP_MOV    4'd1
`define OP_ADD    4'd2
`define OP_SUB    4'd3
`define OP_ASR    4'd4
`define OP_ASL    4'd5
`define OP_OR     4'd6
`define OP_AND    4'd7
`define OP_XOR    4'd8
`define OP_LSL    4'd9
`define OP_LSR    4'd10
`define OP_CND    4'd11
`define OP_LD     4'd12
`define OP_LDA    4'd13
`define OP_ST     4'd14
`define OP_CBR    4'd15
`define ALU_NOP   4'd0
`define ALU_MOV   4'd1
`define ALU_ADD   4'd2
`define ALU_SUB   4'd3
`define ALU_ASR   4'd4
`define ALU_ASL   4'd5
`define ALU_OR    4'd6
`define ALU_AND   4'd7
`define ALU_XOR   4'd8
`define ALU_LSL   4'd9
`define ALU_LSR   4'd10
`define ALU_CND   4'd11
`define RAM_NONE  2'd0
`define RAM_READ  2'd1
`define RAM_WRITE 2'd2
`define WB_NONE   2'd0
`define WB_RAM    2'd1
`define WB_PC     2'd2
`define WB_ALU    2'd3
`endif

module tb_control_seq;

  localparam int DW = 32, RW = 5, IW = 16, TO = 4, CW = 16, W = 60;

  logic          clk = 1'b0;
  logic          rst, run, inst_valid, inst_ready, ram_ack;
  logic [3:0]    inst;
  logic [IW-1:0] ir;
  logic [RW-1:0] reg0, reg1;
  logic [DW-1:0] val0, val1, pc_inc;
  logic [1:0]    ram_action, wb_type, state;
  logic [DW-1:0] ram_addr, pc_jump;
  logic [3:0]    alu_action;
  logic [RW-1:0] wb_reg;
  logic          wb_en, do_jump, retire, core_run, halt, fault;
  logic [CW-1:0] retired;

  logic [W-1:0]  exp_q[$];
  int            checks = 0;
  int            errors = 0;
  logic [CW-1:0] ret_cnt = '0;

  control_seq #(.DW(DW), .RW(RW), .IW(IW), .TIMEOUT(TO), .CW(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_run(run),
    .i_inst_valid(inst_valid), .o_inst_ready(inst_ready),
    .i_inst(inst), .i_ir(ir), .i_reg0(reg0), .i_reg1(reg1),
    .i_val_reg0(val0), .i_val_reg1(val1), .i_pc_inc(pc_inc),
    .i_ram_ack(ram_ack), .o_ram_action(ram_action), .o_ram_addr(ram_addr),
    .o_alu_action(alu_action), .o_wb_reg(wb_reg), .o_wb_type(wb_type),
    .o_wb_en(wb_en), .o_do_jump(do_jump), .o_pc_jump(pc_jump),
    .o_retire(retire), .o_retired(retired), .o_run(core_run),
    .o_halt(halt), .o_fault(fault), .o_state(state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference record: {wb_type, wb_reg, alu, do_jump, pc_jump, retired}
  function automatic logic [W-1:0] model(input logic [3:0] op, input logic [RW-1:0] r0,
      input logic [RW-1:0] r1, input logic [DW-1:0] v0, input logic [DW-1:0] v1,
      input logic [DW-1:0] pc, input logic [CW-1:0] ret);
    logic [3:0]    alu;
    logic [1:0]    wt;
    logic          j;
    logic [DW-1:0] tgt;
    case (op)
      `OP_MOV: alu = `ALU_MOV;  `OP_ADD: alu = `ALU_ADD;  `OP_SUB: alu = `ALU_SUB;
      `OP_ASR: alu = `ALU_ASR;  `OP_ASL: alu = `ALU_ASL;  `OP_OR:  alu = `ALU_OR;
      `OP_AND: alu = `ALU_AND;  `OP_XOR: alu = `ALU_XOR;  `OP_LSL: alu = `ALU_LSL;
      `OP_LSR: alu = `ALU_LSR;  `OP_CND: alu = `ALU_CND;
      default: alu = `ALU_NOP;
    endcase
    if (op == `OP_LD || op == `OP_LDA) wt = `WB_RAM;
    else if (op == `OP_CBR)            wt = `WB_PC;
    else if (alu != `ALU_NOP)          wt = `WB_ALU;
    else                               wt = `WB_NONE;
    j = 1'b0;
    tgt = '0;
    if (op == `OP_CBR && v0 != 0) begin j = 1'b1; tgt = v1; end
    if (op == `OP_LDA) begin j = 1'b1; tgt = pc + 32'd4; end
    return {wt, (op == `OP_CBR) ? r0 : r1, alu, j, tgt, ret};
  endfunction

  task automatic issue(input logic [3:0] op, input logic [IW-1:0] ir_v,
      input logic [RW-1:0] r0, input logic [RW-1:0] r1,
      input logic [DW-1:0] v0, input logic [DW-1:0] v1, input logic [DW-1:0] pc);
    inst = op; ir = ir_v; reg0 = r0; reg1 = r1; val0 = v0; val1 = v1; pc_inc = pc;
    inst_valid = 1'b1;
    if (ir_v != 0) begin
      ret_cnt = ret_cnt + 1'b1;
      exp_q.push_back(model(op, r0, r1, v0, v1, pc, ret_cnt));
    end
    tick();
    inst_valid = 1'b0;
    inst = $urandom_range(0, 15);
    val0 = $urandom; val1 = $urandom; pc_inc = $urandom;
  endtask

  task automatic wb_check(input string tag, input logic exp_en);
    logic [W-1:0] e, o;
    check({tag, "_retire"}, retire, 1'b1);
    check({tag, "_wb_en"}, wb_en, exp_en);
    if (exp_q.size() == 0) begin
      check({tag, "_unexpected_wb"}, 1'b1, 1'b0);
    end else begin
      e = exp_q.pop_front();
      o = {wb_type, wb_reg, alu_action, do_jump, e[48] ? pc_jump : 32'd0, retired};
      check({tag, "_wb_rec"}, o, e);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; inst_valid = 1'b0; ram_ack = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    ret_cnt = '0;
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ram_action"}, ram_action, `RAM_NONE);
    check({tag, "_ram_addr"}, ram_addr, 0);
    check({tag, "_alu"}, alu_action, `ALU_NOP);
    check({tag, "_wb_type"}, wb_type, `WB_NONE);
    check({tag, "_strobes"}, {wb_en, do_jump, retire}, 3'b000);
    check({tag, "_retired"}, retired, 0);
    check({tag, "_flags"}, {halt, fault}, 2'b00);
    check({tag, "_ready"}, inst_ready, 1'b1);
  endtask

  initial begin
    rst = 1'b1; run = 1'b1; inst_valid = 1'b0; ram_ack = 1'b0;
    inst = '0; ir = '0; reg0 = '0; reg1 = '0; val0 = '0; val1 = '0; pc_inc = '0;
    do_reset();
    check_reset_outputs("reset");

    // ADD: WB next cycle, ready the cycle after
    issue(`OP_ADD, 16'h1234, 5'd1, 5'd3, 32'h11, 32'h22, 32'h8);
    check("add_ready_in_wb", inst_ready, 1'b0);
    check("add_alu", alu_action, `ALU_ADD);
    wb_check("add", 1'b1);
    tick();
    check("add_ready_again", inst_ready, 1'b1);

    // SPEC: retires without writeback
    issue(`OP_SPEC, 16'h0001, 5'd2, 5'd4, 32'h0, 32'h0, 32'h0);
    wb_check("spec", 1'b0);
    tick();

    // LD with ack in the third MEM cycle
    issue(`OP_LD, 16'h5000, 5'd6, 5'd9, 32'h100, 32'h777, 32'h30);
    for (int k = 1; k <= 3; k++) begin
      check($sformatf("ld_action_c%0d", k), ram_action, `RAM_READ);
      check($sformatf("ld_addr_c%0d", k), ram_addr, 32'h100);
      if (k == 3) ram_ack = 1'b1;
      tick();
    end
    ram_ack = 1'b0;
    check("ld_ram_idle_in_wb", ram_action, `RAM_NONE);
    wb_check("ld", 1'b1);
    tick();

    // LDA with immediate ack: jump past the literal
    issue(`OP_LDA, 16'h6000, 5'd0, 5'd5, 32'h999, 32'h888, 32'h20);
    check("lda_action", ram_action, `RAM_READ);
    check("lda_addr", ram_addr, 32'h20);
    ram_ack = 1'b1;
    tick();
    ram_ack = 1'b0;
    wb_check("lda", 1'b1);
    tick();

    // CBR not taken, then taken
    issue(`OP_CBR, 16'h7000, 5'd7, 5'd2, 32'h0, 32'h40, 32'h50);
    wb_check("cbr_nt", 1'b1);
    tick();
    issue(`OP_CBR, 16'h7001, 5'd7, 5'd2, 32'h5, 32'h40, 32'h50);
    wb_check("cbr_t", 1'b1);
    tick();
    check("queue_empty_1", exp_q.size(), 0);

    // ST with no ack: fault after TO MEM cycles
    issue(`OP_ST, 16'h8000, 5'd1, 5'd2, 32'h3, 32'h80, 32'h0);
    for (int k = 1; k <= TO; k++) begin
      check($sformatf("st_to_action_c%0d", k), ram_action, `RAM_WRITE);
      check($sformatf("st_to_addr_c%0d", k), ram_addr, 32'h80);
      check($sformatf("st_to_nofault_c%0d", k), fault, 1'b0);
      tick();
    end
    check("to_fault", fault, 1'b1);
    check("to_halt", halt, 1'b1);
    check("to_ram_none", ram_action, `RAM_NONE);
    check("to_ready", inst_ready, 1'b0);
    check("to_run", core_run, 1'b0);
    void'(exp_q.pop_back());
    tick();
    check("to_still_halt", halt, 1'b1);

    // Same ST, ack on the last allowed cycle: no fault
    do_reset();
    check_reset_outputs("reset2");
    issue(`OP_ST, 16'h8001, 5'd1, 5'd2, 32'h3, 32'h84, 32'h0);
    for (int k = 1; k <= TO; k++) begin
      check($sformatf("st_ack_addr_c%0d", k), ram_addr, 32'h84);
      if (k == TO) ram_ack = 1'b1;
      tick();
    end
    ram_ack = 1'b0;
    check("st_ack_nofault", fault, 1'b0);
    wb_check("st_ack", 1'b0);
    tick();

    // i_run low mid-MEM does not abort the load
    issue(`OP_LD, 16'h5001, 5'd3, 5'd4, 32'h200, 32'h0, 32'h0);
    run = 1'b0;
    tick();
    check("runlow_action", ram_action, `RAM_READ);
    check("runlow_o_run", core_run, 1'b0);
    ram_ack = 1'b1;
    tick();
    ram_ack = 1'b0;
    wb_check("runlow", 1'b1);
    tick();
    check("runlow_not_ready", inst_ready, 1'b0);
    run = 1'b1;

    // Zero instruction halts
    issue(`OP_ADD, 16'h0000, 5'd1, 5'd1, 32'h1, 32'h1, 32'h1);
    check("halt_flag", halt, 1'b1);
    check("halt_run", core_run, 1'b0);
    check("halt_ready", inst_ready, 1'b0);
    check("halt_no_retire", retire, 1'b0);
    tick();
    check("halt_held", halt, 1'b1);

    // Reset in the middle of a load
    do_reset();
    issue(`OP_LD, 16'h5002, 5'd3, 5'd4, 32'h300, 32'h0, 32'h0);
    check("mid_ld_action", ram_action, `RAM_READ);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check_reset_outputs("mid_ld_reset");
    check("queue_empty_end", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_seq.md
Name: control_seq

Overview:
- Multi-cycle successor to the combinational instruction control unit.
- Accepts one decoded instruction per handshake and latches its operands.
- Sequences memory access with an acknowledge and a timeout, then issues one-cycle writeback and jump strobes.
- Parametrised in data width, register-index width, instruction width and memory timeout. Adds halt/fault state and a retired-instruction counter.
- Sits between the decoder/register file and the ALU, RAM port and PC logic.

Parameters:
- DW, 32, data and address width; literal skip for LDA is DW/8 bytes.
- RW, 5, register index width.
- IW, 16, instruction register width.
- TIMEOUT, 255, maximum MEM cycles without i_ram_ack before fault; 0 disables the timeout.
- CW, 16, retired-instruction counter width.

Ports:
- i_clk  in  1  single clock; all state changes on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_run  in  1  run enable from the top level.
- i_inst_valid  in  1  decoder offers an instruction.
- o_inst_ready  out  1  block can accept an instruction.
- i_inst  in  4  opcode, using the `OP_* encodings.
- i_ir  in  IW  raw instruction; all-zero means halt.
- i_reg0, i_reg1  in  RW  register indices.
- i_val_reg0, i_val_reg1  in  DW  register values.
- i_pc_inc  in  DW  incremented PC.
- i_ram_ack  in  1  memory transaction complete.
- o_ram_action  out  2  `RAM_NONE/`RAM_READ/`RAM_WRITE.
- o_ram_addr  out  DW  memory address.
- o_alu_action  out  4  `ALU_* code.
- o_wb_reg  out  RW  writeback register.
- o_wb_type  out  2  `WB_NONE/`WB_RAM/`WB_PC/`WB_ALU.
- o_wb_en  out  1  one-cycle writeback strobe.
- o_do_jump  out  1  one-cycle jump strobe.
- o_pc_jump  out  DW  jump target.
- o_retire  out  1  one-cycle retire strobe.
- o_retired  out  CW  retired-instruction count.
- o_run  out  1  core running.
- o_halt  out  1  halted.
- o_fault  out  1  memory timeout occurred.

Behaviour:
- Reset and outputs:
  - i_rst at an edge forces state IDLE and zeroes all latches, counters and flags.
  - After reset: strobes 0, o_ram_action=`RAM_NONE, o_alu_action=`ALU_NOP, o_wb_type=`WB_NONE, addresses and o_retired 0.
  - Reset during MEM aborts the transaction; o_ram_action is `RAM_NONE on the next cycle.
  - All outputs are derived from the state and latched fields only; none is combinational from i_*, except o_inst_ready and o_run, which also depend on i_run.
- States: IDLE, MEM, WB, HALT.
- IDLE:
  - o_inst_ready = i_run.
  - On i_inst_valid && o_inst_ready, latch i_inst, i_ir, indices, values and i_pc_inc.
  - Latched i_ir == 0 -> HALT.
  - Opcode LD/LDA/ST -> MEM.
  - Otherwise -> WB.
- MEM:
  - o_ram_action: READ for LD/LDA, WRITE for ST.
  - o_ram_addr: LD = val_reg0, LDA = pc_inc, ST = val_reg1.
  - Action and address are held stable until ack.
  - i_ram_ack -> WB.
  - A wait counter increments each MEM cycle without ack. With TIMEOUT != 0 and the count reaching TIMEOUT: o_fault=1 and -> HALT.
  - Ack in the same cycle as the timeout: ack wins, no fault.
  - i_run low during MEM does not abort; the transaction completes.
- WB (exactly one cycle):
  - o_retire=1.
  - o_wb_en = (wb_type != `WB_NONE).
  - o_retired increments and wraps modulo 2^CW.
  - Next state IDLE.
- Writeback and jump rules (latched values):
  - wb_type: LD/LDA -> `WB_RAM; CBR -> `WB_PC; nonzero ALU op -> `WB_ALU; else `WB_NONE.
  - wb_reg: reg0 for CBR, reg1 otherwise.
  - ALU map: MOV/ADD/SUB/ASR/ASL/OR/AND/XOR/LSL/LSR/CND -> matching `ALU_*; SPEC/LD/LDA/ST/CBR -> `ALU_NOP.
  - o_do_jump: CBR with val_reg0 != 0, pc_jump = val_reg1. LDA always, pc_jump = pc_inc + DW/8 (modulo 2^DW).
- HALT: o_halt=1, o_inst_ready=0, o_run=0; left only by reset.
- o_run = i_run && !o_halt.
- Latency:
  - Non-memory instruction accepted at cycle N: WB at N+1, ready again at N+2.
  - Memory instruction with ack at cycle M: WB at M+1, ready at M+2.

Test Plan:
- Reset, then ADD (i_ir=16'h1234, reg1=3) accepted at cycle 1 -> cycle 2: o_wb_en=1, o_wb_type=`WB_ALU, o_alu_action=`ALU_ADD, o_wb_reg=3, o_retired=1; ready again at cycle 3.
- LD with val_reg0=32'h100, ack after 3 MEM cycles -> o_ram_action=`RAM_READ, o_ram_addr=32'h100 for all 3 cycles; then WB with `WB_RAM and no jump.
- LDA with pc_inc=32'h20, ack in the first MEM cycle -> o_ram_addr=32'h20; in WB, o_do_jump=1, o_pc_jump=32'h24.
- CBR with val_reg0=0 then val_reg0=5, val_reg1=32'h40 -> first: o_do_jump=0; second: o_do_jump=1, o_pc_jump=32'h40, o_wb_type=`WB_PC, o_wb_reg=reg0.
- TIMEOUT=4, ST with no ack -> o_fault=1 and o_halt=1 after the 4th MEM cycle, o_ram_action=`RAM_NONE, o_inst_ready=0. Repeat with ack on the 4th cycle -> no fault.
- i_ir=0 accepted -> HALT with o_run=0. Then i_rst in MEM mid-LD -> IDLE, all outputs at reset values on the next cycle.
